npc_predict_unit: RTL

Parametrised next-PC unit for the fetch stage: owns the PC register, predicts the next fetch address with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters, and resolves control instructions in D. Resolution uses the existing jump encoding (beq/jal/jr/bne). On a misprediction it flushes the younger fetch and redirects the PC. Sits between the IF stage (PC to instruction memory) and the D-stage decode/compare logic.

---
 rtl/npc_predict_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/npc_predict_unit.sv
// npc_predict_unit: fetch PC register with BTB/2-bit-counter prediction and D-stage branch resolution
module npc_predict_unit #(
    parameter int ADDR_W = 32,
    parameter int ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [2:0]        jump_signal,
    input  logic [15:0]       addr16,
    input  logic [25:0]       addr26,
    input  logic [ADDR_W-1:0] rs,
    input  logic              cmp_eq,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_pred_target,
    output logic              flush,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              v   [ENTRIES];
    logic [TAG_W-1:0]  tag [ENTRIES];
    logic [ADDR_W-1:0] tgt [ENTRIES];
    logic [1:0]        ctr [ENTRIES];
    logic              unc [ENTRIES];

    logic [IDX_W-1:0]  idx, ridx;
    logic [TAG_W-1:0]  rtag;
    logic              hit, rhit, is_beq, is_jal, is_jr, is_bne, ctrl, uncond, taken;
    logic [ADDR_W-1:0] seq, act_tgt, redirect;

    // Lookup on the fetch PC and resolution of the D-stage instruction
    always_comb begin
        idx = pc[IDX_W+1:2];
        hit = v[idx] && tag[idx] == pc[ADDR_W-1:IDX_W+2];
        pred_taken = hit && (unc[idx] || ctr[idx][1]);
        pred_target = pred_taken ? tgt[idx] : pc + ADDR_W'(4);
        ridx = res_pc[IDX_W+1:2];
        rtag = res_pc[ADDR_W-1:IDX_W+2];
        rhit = v[ridx] && tag[ridx] == rtag;
        is_beq = jump_signal == 3'd1;
        is_jal = jump_signal == 3'd2;
        is_jr = jump_signal == 3'd3;
        is_bne = jump_signal == 3'd4;
        ctrl = is_beq || is_jal || is_jr || is_bne;
        uncond = is_jal || is_jr;
        taken = uncond || (is_beq && cmp_eq) || (is_bne && !cmp_eq);
        seq = res_pc + ADDR_W'(4);
        act_tgt = is_jr ? rs : is_jal ? {seq[ADDR_W-1:28], addr26, 2'b00}
                : seq + {{(ADDR_W-18){addr16[15]}}, addr16, 2'b00};
        redirect = taken ? act_tgt : seq;
        flush = res_valid && !reset && (taken != res_pred_taken
                || (taken && res_pred_taken && act_tgt != res_pred_target));
    end

    // PC register: a redirect beats stall, otherwise follow the prediction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else if (flush) pc <= redirect;
        else if (!stall) pc <= pred_target;
    end

    // BTB valid/counter/uncond state: train on hits, allocate on taken misses, drop aliases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                v[i] <= 1'b0;
                ctr[i] <= 2'b00;
                unc[i] <= 1'b0;
            end
        end else if (res_valid) begin
            if (ctrl && rhit) begin
                ctr[ridx] <= taken ? (ctr[ridx] == 2'b11 ? 2'b11 : ctr[ridx] + 2'd1)
                                   : (ctr[ridx] == 2'b00 ? 2'b00 : ctr[ridx] - 2'd1);
                if (uncond) unc[ridx] <= 1'b1;
            end else if (ctrl && taken) begin
                v[ridx] <= 1'b1;
                ctr[ridx] <= uncond ? 2'b11 : 2'b10;
                unc[ridx] <= uncond;
            end else if (!ctrl && rhit) begin
                v[ridx] <= 1'b0;
            end
        end
    end

    // BTB tag/target payload, meaningful only while the entry is valid
    always_ff @(posedge clk) begin
        if (res_valid && ctrl && taken) begin
            tgt[ridx] <= act_tgt;
            if (!rhit) tag[ridx] <= rtag;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (res_valid && ctrl && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
            if (flush && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end
endmodule
